// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// The CPU side never stalls. A write to a full FIFO is discarded and latched
// into a sticky overflow flag. Frames leave back-to-back while bytes are queued.
//
//  state | meaning
//  IDLE  | line high, waiting for a queued byte
//  START | start bit (low) for DIV cycles
//  DATA  | eight data bits, LSB first, DIV cycles each
//  STOP  | stop bit (high) for DIV cycles, then next byte or IDLE
module uart_tx_fifo #(
  parameter int SYSCLK_FREQ = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       txp
);

  localparam int DIV = SYSCLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            push, pop, drop;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            txp_nxt;
  logic            bit_end;

  // Flags come only from registered count and state, never from wr_en.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE) || !empty;
  assign push    = wr_en && !full;
  assign drop    = wr_en && full;
  assign bit_end = (cnt == CNT_LAST);

  // FIFO storage; data is captured only on the accepting edge.
  always_ff @(posedge sysclk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky record of any dropped write.
  always_ff @(posedge sysclk) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // Serialiser state register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      txp   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
      txp   <= txp_nxt;
    end
  end

  // Next-state, bit timing and FIFO pop decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    txp_nxt   = txp;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txp_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shreg_nxt = mem[rptr];
          txp_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          txp_nxt   = shreg[0];
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == 3'd7) begin
            txp_nxt   = 1'b1;
            state_nxt = STOP;
          end else begin
            idx_nxt   = idx + 3'd1;
            shreg_nxt = {1'b0, shreg[7:1]};
            txp_nxt   = shreg[1];
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (!empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop       = 1'b1;
            shreg_nxt = mem[rptr];
            txp_nxt   = 1'b0;
            state_nxt = START;
          end else begin
            txp_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        txp_nxt   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed stimulus pushes expected bytes into a
// scoreboard queue; an independent UART receiver samples txp mid-bit and compares.
module tb_uart_tx_fifo;

  localparam int DIV = 16;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       wr_en  = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, overflow, txp;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rx_frames = 0;

  logic [7:0] exp_q [$];

  uart_tx_fifo #(.SYSCLK_FREQ(1600), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .overflow(overflow), .txp(txp)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART receiver: start detected on first low sample, bits sampled at mid-bit.
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge sysclk) begin
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (txp === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == DIV / 2) begin
        check("rx_start_bit", 32'(txp), 32'h0);
      end else if (rx_cnt >= DIV + DIV / 2 && rx_cnt <= 8 * DIV + DIV / 2
                   && ((rx_cnt - DIV / 2) % DIV) == 0) begin
        rx_byte[(rx_cnt - DIV - DIV / 2) / DIV] = txp;
      end else if (rx_cnt == 9 * DIV + DIV / 2) begin
        check("rx_stop_bit", 32'(txp), 32'h1);
        rx_frames++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected_frame: got %0h expected none", rx_byte);
        end else begin
          check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
        rx_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    wr_data = b;
    wr_en = 1'b1;
    if (expect_it) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
    wr_data = ~b;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    @(negedge sysclk);
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= maxc) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got busy=%0b expected 0 within %0d cycles", name, busy, maxc);
    end
    // let the receiver finish its last mid-bit sample
    repeat (DIV) @(negedge sysclk);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    logic [9:0]  frame;
    logic [7:0]  b4 [6];
    int          t1c, frames0, lows, d;

    // 1: reset then idle
    repeat (3) tick();
    reset = 1'b0;
    tick();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      if ({txp, empty, busy, full, overflow} !== 5'b11000) lows++;
    end
    check("t1_idle_flags_bad_cycles", 32'(lows), 32'h0);
    tick();

    // 2: single byte 0xA5, cycle-exact waveform
    frame = {1'b1, 8'hA5, 1'b0};
    push_byte(8'hA5, 1'b1);
    @(negedge sysclk);
    check("t2_txp_before_pop", 32'(txp), 32'h1);
    lows = 0;
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge sysclk);
      if (txp !== frame[k / DIV]) lows++;
      if (k == 1)   check("t2_empty_after_pop", 32'(empty), 32'h1);
      if (k == 159) check("t2_busy_last_cycle", 32'(busy), 32'h1);
    end
    check("t2_waveform_bad_cycles", 32'(lows), 32'h0);
    @(negedge sysclk);
    check("t2_busy_fall", 32'(busy), 32'h0);
    wait_idle("t2", 100);

    // 3: three back-to-back frames in exactly 480 cycles
    tick();
    frames0 = rx_frames;
    push_byte(8'h00, 1'b1);
    t1c = cyc;
    push_byte(8'hFF, 1'b1);
    push_byte(8'h55, 1'b1);
    d = 0;
    while (busy !== 1'b0 && d < 2000) begin
      @(negedge sysclk);
      d++;
    end
    check("t3_busy_fall_offset", 32'(cyc - t1c), 32'd481);
    wait_idle("t3", 100);
    check("t3_frames", 32'(rx_frames - frames0), 32'd3);

    // 4: six consecutive pushes, sixth dropped
    tick();
    frames0 = rx_frames;
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33;
    b4[3] = 8'h44; b4[4] = 8'h5A; b4[5] = 8'hC3;
    for (int i = 0; i < 6; i++) begin
      wr_data = b4[i];
      wr_en = 1'b1;
      if (i < 5) exp_q.push_back(b4[i]);
      @(negedge sysclk);
      if (i == 4) check("t4_full_before_5th", 32'(full), 32'h0);
      if (i == 5) begin
        check("t4_full_before_6th", 32'(full), 32'h1);
        check("t4_ovf_before_6th", 32'(overflow), 32'h0);
      end
      tick();
    end
    wr_en = 1'b0;
    @(negedge sysclk);
    check("t4_ovf_set", 32'(overflow), 32'h1);
    wait_idle("t4", 1200);
    check("t4_frames", 32'(rx_frames - frames0), 32'd5);
    check("t4_ovf_sticky", 32'(overflow), 32'h1);

    // 5: reset mid-DATA with two bytes queued
    tick();
    frames0 = rx_frames;
    push_byte(8'h3C, 1'b0);
    push_byte(8'h77, 1'b0);
    push_byte(8'h99, 1'b0);
    repeat (60) tick();
    @(negedge sysclk);
    check("t5_busy_pre_reset", 32'(busy), 32'h1);
    check("t5_empty_pre_reset", 32'(empty), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge sysclk);
    check("t5_txp_after_reset", 32'(txp), 32'h1);
    check("t5_empty_after_reset", 32'(empty), 32'h1);
    check("t5_busy_after_reset", 32'(busy), 32'h0);
    check("t5_ovf_after_reset", 32'(overflow), 32'h0);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sysclk);
      if (txp !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t5_quiet_bad_cycles", 32'(lows), 32'h0);
    check("t5_no_frames", 32'(rx_frames - frames0), 32'h0);
    tick();
    push_byte(8'h81, 1'b1);
    wait_idle("t5", 300);
    check("t5_frames_after", 32'(rx_frames - frames0), 32'd1);

    // 6: random bytes, spaced slower than the line rate
    frames0 = rx_frames;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(165, 240)) tick();
    end
    wait_idle("t6", 400);
    check("t6_frames", 32'(rx_frames - frames0), 32'd8);
    check("t6_no_overflow", 32'(overflow), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
